// File: rtl/instr_encoder.sv
// RV32I instruction encoder: symbolic fields in, 32-bit machine words out, LI expanded to LUI+ADDI.
// Define ENCODER_RANGE_CHECK_EN to reject out-of-range, misaligned or low-bit-dirty immediates.
module instr_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_class,
    input  logic [2:0]           req_func3,
    input  logic                 req_alt,
    input  logic [4:0]           req_rd,
    input  logic [4:0]           req_rs1,
    input  logic [4:0]           req_rs2,
    input  logic [31:0]          req_imm,
    input  logic [11:0]          req_csr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_last,
    output logic                 err_valid,
    output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef ENCODER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [1:0] {IDLE, HOLD, LI2} state_t;

    state_t                 state, state_next;
    logic [31:0]            instr_q, instr_next;
    logic [31:0]            pend_q, pend_next;
    logic                   last_q, last_next;
    logic                   err_q;
    logic [ERR_CNT_W-1:0]   cnt_q;

    logic [31:0] word0, word1;
    logic        two_beat, class_ok, range_ok, legal, accept;
    logic        fits12, fits13, fits21;
    logic [19:0] li_hi;

    assign fits12 = (req_imm[31:11] == {21{req_imm[11]}});
    assign fits13 = (req_imm[31:12] == {20{req_imm[12]}});
    assign fits21 = (req_imm[31:20] == {12{req_imm[20]}});
    // Rounds the upper part so the sign-extended ADDI low part lands back on imm.
    assign li_hi  = req_imm[31:12] + {19'd0, req_imm[11]};

    always_comb begin
        word0    = '0;
        word1    = '0;
        two_beat = 1'b0;
        class_ok = 1'b1;
        range_ok = 1'b1;
        case (req_class)
            4'd0: begin
                class_ok = !req_alt || (req_func3 == 3'd0) || (req_func3 == 3'd5);
                word0    = {1'b0, req_alt, 5'd0, req_rs2, req_rs1, req_func3, req_rd, OP_R};
            end
            4'd1: begin
                if (req_func3 == 3'd1 || req_func3 == 3'd5) begin
                    range_ok = (req_imm[31:5] == '0);
                    word0    = {1'b0, req_alt, 5'd0, req_imm[4:0], req_rs1, req_func3, req_rd, OP_I};
                end else begin
                    range_ok = fits12;
                    word0    = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_I};
                end
            end
            4'd2: begin
                class_ok = !((req_func3 == 3'd3) || (req_func3 == 3'd6) || (req_func3 == 3'd7));
                range_ok = fits12;
                word0    = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_LOAD};
            end
            4'd3: begin
                class_ok = (req_func3 <= 3'd2);
                range_ok = fits12;
                word0    = {req_imm[11:5], req_rs2, req_rs1, req_func3, req_imm[4:0], OP_STORE};
            end
            4'd4: begin
                class_ok = (req_func3 != 3'd2) && (req_func3 != 3'd3);
                range_ok = fits13 && !req_imm[0];
                word0    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_func3,
                            req_imm[4:1], req_imm[11], OP_BRANCH};
            end
            4'd5, 4'd6: begin
                range_ok = (req_imm[11:0] == '0);
                word0    = {req_imm[31:12], req_rd, (req_class == 4'd5) ? OP_LUI : OP_AUIPC};
            end
            4'd7: begin
                range_ok = fits21 && !req_imm[0];
                word0    = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            end
            4'd8: begin
                class_ok = (req_func3 == 3'd0);
                range_ok = fits12;
                word0    = {req_imm[11:0], req_rs1, 3'd0, req_rd, OP_JALR};
            end
            4'd9: begin
                class_ok = (req_func3 != 3'd0) && (req_func3 != 3'd4);
                word0    = {req_csr, req_rs1, req_func3, req_rd, OP_SYSTEM};
            end
            4'd10: begin
                if (fits12) begin
                    word0 = {req_imm[11:0], 5'd0, 3'd0, req_rd, OP_I};
                end else begin
                    word0    = {li_hi, req_rd, OP_LUI};
                    word1    = {req_imm[11:0], req_rd, 3'd0, req_rd, OP_I};
                    two_beat = (req_imm[11:0] != '0);
                end
            end
            default: class_ok = 1'b0;
        endcase
    end

    assign legal     = class_ok && (range_ok || !RANGE_CHECK);
    assign req_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state;
        instr_next = instr_q;
        last_next  = last_q;
        pend_next  = pend_q;
        if (accept && legal) begin
            instr_next = word0;
            last_next  = !two_beat;
            pend_next  = word1;
            state_next = two_beat ? LI2 : HOLD;
        end else if (accept) begin
            state_next = ((state == HOLD) && !out_ready) ? HOLD : IDLE;
        end else if (out_ready) begin
            if (state == HOLD) begin
                state_next = IDLE;
            end else if (state == LI2) begin
                instr_next = pend_q;
                last_next  = 1'b1;
                state_next = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            instr_q <= '0;
            pend_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            instr_q <= instr_next;
            pend_q  <= pend_next;
            last_q  <= last_next;
            err_q   <= accept && !legal;
            if (accept && !legal && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_valid = (state != IDLE);
    assign out_instr = instr_q;
    assign out_last  = last_q;
    assign err_valid = err_q;
    assign err_cnt   = cnt_q;

endmodule
